// File: rtl/cp0_ctrl_if.sv
// CP0 control bus: mtc0/mfc0 access, commit-point exception inputs and redirect outputs.
// master drives the commit-point side; slave is the cp0_ctrl block.
interface cp0_ctrl_if;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] vpc;
    logic        is_bd;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    modport master (
        output en, addr, wdata, vpc, is_bd, exc_code, hw_int, eret,
        input  rdata, req, epc_out
    );

    modport slave (
        input  en, addr, wdata, vpc, is_bd, exc_code, hw_int, eret,
        output rdata, req, epc_out
    );
endinterface

// File: rtl/cp0_ctrl.sv
// Minimal MIPS CP0: SR(12), Cause(13), EPC(14), exception/interrupt request and eret return address.
// Optional feature: define CP0_PRID_EN to make register 15 read the constant PRId 32'h0000_7CA0.
module cp0_ctrl (
    input  logic        clk,
    input  logic        reset,
    cp0_ctrl_if.slave   bus
);
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        req_i;

    assign int_req = (|(bus.hw_int & im)) & ie & ~exl;
    assign exc_req = (bus.exc_code != 5'd0) & ~exl;
    // Registers already read zero in reset; gating keeps an exc_code from raising req meanwhile.
    assign req_i   = (int_req | exc_req) & reset;
    assign bus.req = req_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im  <= '0;
            exl <= 1'b0;
            ie  <= 1'b0;
            bd  <= 1'b0;
            ip  <= '0;
            exc <= '0;
            epc <= '0;
        end else begin
            ip <= bus.hw_int;
            if (req_i) begin
                exl <= 1'b1;
                bd  <= bus.is_bd;
                exc <= int_req ? 5'd0 : bus.exc_code;
                epc <= (bus.is_bd ? bus.vpc - 32'd4 : bus.vpc) & 32'hFFFF_FFFC;
            end else begin
                if (bus.eret)
                    exl <= 1'b0;
                if (bus.en) begin
                    case (bus.addr)
                        5'd12: begin
                            im  <= bus.wdata[15:10];
                            exl <= bus.wdata[1];
                            ie  <= bus.wdata[0];
                        end
                        5'd14:   epc <= bus.wdata & 32'hFFFF_FFFC;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            5'd12: bus.rdata = {16'd0, im, 8'd0, exl, ie};
            5'd13: bus.rdata = {bd, 15'd0, ip, 3'd0, exc, 2'd0};
            5'd14: bus.rdata = epc;
`ifdef CP0_PRID_EN
            5'd15: bus.rdata = 32'h0000_7CA0;
`endif
            default: bus.rdata = '0;
        endcase
    end

    always_comb begin
        if (!reset)
            bus.epc_out = '0;
        else if (bus.en && bus.addr == 5'd14)
            bus.epc_out = bus.wdata & 32'hFFFF_FFFC;
        else
            bus.epc_out = epc;
    end
endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed scenarios plus random traffic against a word-level model.
module tb_cp0_ctrl;
    logic clk = 1'b0;
    logic reset;

    cp0_ctrl_if bus();

    cp0_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Architectural state as whole register words.
    logic [31:0] m_sr, m_cause, m_epc;

`ifdef CP0_PRID_EN
    localparam logic [31:0] PRID_EXP = 32'h0000_7CA0;
`else
    localparam logic [31:0] PRID_EXP = 32'h0000_0000;
`endif

    function automatic logic m_int();
        return reset && ((bus.hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_exc();
        return reset && (bus.exc_code != 5'd0) && !m_sr[1];
    endfunction

    function automatic logic [31:0] m_rdata();
        case (bus.addr)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID_EXP;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_epc_out();
        if (!reset) return 32'd0;
        if (bus.en && bus.addr == 5'd14) return bus.wdata & ~32'd3;
        return m_epc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        #1;
        chk({tag, "/req"}, {31'd0, bus.req}, {31'd0, m_int() | m_exc()});
        chk({tag, "/rdata"}, bus.rdata, m_rdata());
        chk({tag, "/epc_out"}, bus.epc_out, m_epc_out());
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(tag, bus.rdata, exp);
    endtask

    task automatic zero_model();
        m_sr = '0; m_cause = '0; m_epc = '0;
    endtask

    task automatic set_reset(input logic v);
        reset = v;
        if (!v) zero_model();
    endtask

    // Next register words computed from the current inputs, committed at the edge.
    task automatic tick();
        logic [31:0] n_sr, n_cause, n_epc;
        logic        ir, er;
        ir = m_int();
        er = m_exc();
        n_sr = m_sr;
        n_epc = m_epc;
        n_cause = (m_cause & 32'h8000_007C) | (32'(bus.hw_int) << 10);
        if (ir || er) begin
            n_sr = m_sr | 32'd2;
            n_cause = (bus.is_bd ? 32'h8000_0000 : 32'd0) | (32'(bus.hw_int) << 10)
                    | ((ir ? 32'd0 : 32'(bus.exc_code)) << 2);
            n_epc = (bus.is_bd ? bus.vpc - 32'd4 : bus.vpc) & ~32'd3;
        end else begin
            if (bus.eret) n_sr = n_sr & ~32'd2;
            if (bus.en && bus.addr == 5'd12) n_sr = bus.wdata & 32'h0000_FC03;
            if (bus.en && bus.addr == 5'd14) n_epc = bus.wdata & ~32'd3;
        end
        @(posedge clk);
        if (reset) begin
            m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
        end else begin
            zero_model();
        end
        #1;
    endtask

    task automatic idle();
        bus.en = 1'b0; bus.addr = '0; bus.wdata = '0; bus.vpc = '0;
        bus.is_bd = 1'b0; bus.exc_code = '0; bus.hw_int = '0; bus.eret = 1'b0;
    endtask

    initial begin
        idle();
        set_reset(1'b0);

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            bus.en = 1'($urandom); bus.wdata = $urandom; bus.vpc = $urandom;
            bus.exc_code = 5'($urandom); bus.hw_int = 6'($urandom); bus.is_bd = 1'($urandom);
            bus.eret = 1'($urandom); bus.addr = 5'd14;
            #1;
            chk("rst/req", {31'd0, bus.req}, 32'd0);
            chk("rst/epc_out", bus.epc_out, 32'd0);
            rd("rst/sr", 5'd12, 32'd0);
            rd("rst/cause", 5'd13, 32'd0);
            rd("rst/epc", 5'd14, 32'd0);
            tick();
        end
        idle();
        set_reset(1'b1);

        // Interrupt
        bus.en = 1'b1; bus.addr = 5'd12; bus.wdata = 32'h0000_FC01;
        check_outputs("int_wr");
        tick();
        idle();
        bus.hw_int = 6'b000100; bus.vpc = 32'h3010;
        #1;
        chk("int/req", {31'd0, bus.req}, 32'd1);
        check_outputs("int_req");
        tick();
        rd("int/sr", 5'd12, 32'h0000_FC03);
        rd("int/cause", 5'd13, 32'h0000_1000);
        rd("int/epc", 5'd14, 32'h0000_3010);
        idle();
        bus.eret = 1'b1;
        check_outputs("int_eret");
        tick();

        // Delay-slot exception
        idle();
        bus.en = 1'b1; bus.addr = 5'd12; bus.wdata = 32'd0;
        check_outputs("bd_wr");
        tick();
        idle();
        bus.exc_code = 5'd4; bus.is_bd = 1'b1; bus.vpc = 32'h3024;
        #1;
        chk("bd/req", {31'd0, bus.req}, 32'd1);
        tick();
        idle();
        rd("bd/cause", 5'd13, 32'h8000_0010);
        rd("bd/epc", 5'd14, 32'h0000_3020);

        // Nesting: EXL set, enabled interrupt and exception both ignored
        bus.en = 1'b1; bus.addr = 5'd12; bus.wdata = 32'h0000_FC03;
        check_outputs("nest_wr");
        tick();
        idle();
        bus.exc_code = 5'd10; bus.hw_int = 6'b000100; bus.vpc = 32'h4000;
        #1;
        chk("nest/req", {31'd0, bus.req}, 32'd0);
        tick();
        idle();
        rd("nest/epc", 5'd14, 32'h0000_3020);
        rd("nest/cause", 5'd13, 32'h8000_1010);

        // eret with EPC write bypass, then SR write suppressed by an exception
        bus.eret = 1'b1; bus.en = 1'b1; bus.addr = 5'd14; bus.wdata = 32'h3047;
        #1;
        chk("sim/epc_out", bus.epc_out, 32'h0000_3044);
        check_outputs("sim_eret");
        tick();
        idle();
        rd("sim/sr", 5'd12, 32'h0000_FC01);
        bus.en = 1'b1; bus.addr = 5'd12; bus.wdata = 32'd0;
        bus.exc_code = 5'd8; bus.vpc = 32'h5008;
        #1;
        chk("sim/req", {31'd0, bus.req}, 32'd1);
        tick();
        idle();
        rd("sim/sr2", 5'd12, 32'h0000_FC03);
        rd("sim/epc2", 5'd14, 32'h0000_5008);
        rd("sim/cause2", 5'd13, 32'h0000_0020);

        // PRId
        rd("prid", 5'd15, PRID_EXP);

        // Reset during a pending request discards it
        bus.eret = 1'b1;
        check_outputs("mid_eret");
        tick();
        idle();
        bus.exc_code = 5'd12; bus.vpc = 32'h6000;
        #1;
        chk("mid/pending", {31'd0, bus.req}, 32'd1);
        set_reset(1'b0);
        #1;
        chk("mid/req", {31'd0, bus.req}, 32'd0);
        rd("mid/sr", 5'd12, 32'd0);
        tick();
        rd("mid/epc", 5'd14, 32'd0);
        set_reset(1'b1);
        idle();
        bus.en = 1'b1; bus.addr = 5'd14; bus.wdata = 32'h0000_7777;
        check_outputs("post_rst_wr");
        tick();
        idle();
        rd("post_rst/epc", 5'd14, 32'h0000_7774);

        // Random traffic, with vpc near zero to exercise the wrap of vpc-4
        for (int i = 0; i < 600; i++) begin
            bus.en = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0: bus.addr = 5'd12;
                1: bus.addr = 5'd13;
                2: bus.addr = 5'd14;
                3: bus.addr = 5'd15;
                default: bus.addr = 5'($urandom);
            endcase
            bus.wdata = $urandom;
            bus.vpc = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            bus.is_bd = 1'($urandom);
            bus.exc_code = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            bus.hw_int = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            bus.eret = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 99) == 0) set_reset(1'b0);
            check_outputs("rand");
            tick();
            if (!reset) set_reset(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
